// File: rtl/lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// lcd_bus_receiver
//
// Receive-side model of an HD44780-style 8-bit character-LCD bus. The bus
// pins are synchronized into clk_50, each write transfer is latched on the
// falling edge of E, instructions update the display-state registers, and
// data bytes land in a 2x16 character buffer exposed through a registered
// read port.
//
// Ports:
//   clk_50      in   system clock
//   reset       in   asynchronous, active-low
//   lcd_d       in   [7:0] LCD data bus (asynchronous)
//   lcd_rs      in   0 = instruction, 1 = data
//   lcd_rw      in   0 = write, 1 = read (ignored)
//   lcd_e       in   enable strobe, transfer latched on its falling edge
//   rd_addr     in   [4:0] buffer index (0-15 line 1, 16-31 line 2)
//   rd_data     out  [7:0] buffer byte at rd_addr, one cycle later
//   cursor      out  [6:0] address counter (AC)
//   disp_on, cursor_on, blink_on   out  display-control D, C, B
//   entry_inc   out  1 = AC increments after a data write
//   two_line, bus_8bit             out  function-set N and DL
//   busy        out  clear sweep in progress
//   cmd_pulse   out  one-cycle pulse per applied instruction
//   data_pulse  out  one-cycle pulse per applied data write
//   overrun     out  sticky: a transfer arrived during a clear sweep
// ---------------------------------------------------------------------------
module lcd_bus_receiver (
    input  logic       clk_50,
    input  logic       reset,
    input  logic [7:0] lcd_d,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       two_line,
    output logic       bus_8bit,
    output logic       busy,
    output logic       cmd_pulse,
    output logic       data_pulse,
    output logic       overrun
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Bus bit packing: {e, rw, rs, d[7:0]}
    logic [10:0] s1_q, s2_q, s3_q;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [6:0]  ac_q, ac_d;
    logic        disp_on_q, disp_on_d;
    logic        cursor_on_q, cursor_on_d;
    logic        blink_on_q, blink_on_d;
    logic        entry_inc_q, entry_inc_d;
    logic        two_line_q, two_line_d;
    logic        bus_8bit_q, bus_8bit_d;
    logic        cgram_mode_q, cgram_mode_d;
    logic        cmd_pulse_q, cmd_pulse_d;
    logic        data_pulse_q, data_pulse_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  rd_data_q;

    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic [7:0]  buf_mem [0:31];

    logic        e_fall;
    logic        x_rw, x_rs;
    logic [7:0]  x_d;

    // The s3 copy still holds the values present while E was high.
    assign e_fall = s3_q[10] & ~s2_q[10];
    assign x_rw   = s3_q[9];
    assign x_rs   = s3_q[8];
    assign x_d    = s3_q[7:0];

    // AC increment: line 1 end (0x27) jumps to line 2, line 2 end wraps to 0.
    // Out-of-range values count up and naturally reach 0x40 or wrap via 0x7F.
    function automatic logic [6:0] ac_inc(input logic [6:0] a);
        if (a == 7'h27)
            return 7'h40;
        else if (a == 7'h67)
            return 7'h00;
        else
            return a + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] a);
        if (a == 7'h00)
            return 7'h67;
        else if (a == 7'h40)
            return 7'h27;
        else
            return a - 7'd1;
    endfunction

    // -----------------------------------------------------------------------
    // Input synchronizer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= {lcd_e, lcd_rw, lcd_rs, lcd_d};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_SWEEP;
            idx_q        <= '0;
            ac_q         <= '0;
            disp_on_q    <= 1'b0;
            cursor_on_q  <= 1'b0;
            blink_on_q   <= 1'b0;
            entry_inc_q  <= 1'b1;
            two_line_q   <= 1'b0;
            bus_8bit_q   <= 1'b1;
            cgram_mode_q <= 1'b0;
            cmd_pulse_q  <= 1'b0;
            data_pulse_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ac_q         <= ac_d;
            disp_on_q    <= disp_on_d;
            cursor_on_q  <= cursor_on_d;
            blink_on_q   <= blink_on_d;
            entry_inc_q  <= entry_inc_d;
            two_line_q   <= two_line_d;
            bus_8bit_q   <= bus_8bit_d;
            cgram_mode_q <= cgram_mode_d;
            cmd_pulse_q  <= cmd_pulse_d;
            data_pulse_q <= data_pulse_d;
            overrun_q    <= overrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: clear sweep, instruction decode, data writes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ac_d         = ac_q;
        disp_on_d    = disp_on_q;
        cursor_on_d  = cursor_on_q;
        blink_on_d   = blink_on_q;
        entry_inc_d  = entry_inc_q;
        two_line_d   = two_line_q;
        bus_8bit_d   = bus_8bit_q;
        cgram_mode_d = cgram_mode_q;
        cmd_pulse_d  = 1'b0;
        data_pulse_d = 1'b0;
        overrun_d    = overrun_q;
        mem_we       = 1'b0;
        mem_waddr    = idx_q;
        mem_wdata    = 8'h20;

        case (state_q)
            ST_SWEEP: begin
                // Sweep owns the buffer write port; anything arriving now is lost.
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                mem_wdata = 8'h20;
                idx_d     = idx_q + 5'd1;
                if (idx_q == 5'd31)
                    state_d = ST_IDLE;
                if (e_fall)
                    overrun_d = 1'b1;
            end

            default: begin
                if (e_fall && !x_rw) begin
                    if (!x_rs) begin
                        cmd_pulse_d = 1'b1;
                        if (x_d[7]) begin
                            ac_d         = x_d[6:0];
                            cgram_mode_d = 1'b0;
                        end else if (x_d[6]) begin
                            cgram_mode_d = 1'b1;
                        end else if (x_d[5]) begin
                            bus_8bit_d = x_d[4];
                            two_line_d = x_d[3];
                        end else if (x_d[4]) begin
                            // Display shift (d[3]=1) leaves AC alone.
                            if (!x_d[3])
                                ac_d = x_d[2] ? ac_inc(ac_q) : ac_dec(ac_q);
                        end else if (x_d[3]) begin
                            disp_on_d   = x_d[2];
                            cursor_on_d = x_d[1];
                            blink_on_d  = x_d[0];
                        end else if (x_d[2]) begin
                            entry_inc_d = x_d[1];
                        end else if (x_d[1]) begin
                            ac_d         = '0;
                            cgram_mode_d = 1'b0;
                        end else if (x_d[0]) begin
                            state_d      = ST_SWEEP;
                            idx_d        = '0;
                            ac_d         = '0;
                            entry_inc_d  = 1'b1;
                            cgram_mode_d = 1'b0;
                        end
                    end else begin
                        data_pulse_d = 1'b1;
                        // CGRAM writes are accepted on the bus but not modelled.
                        if (!cgram_mode_q) begin
                            if (ac_q[6:4] == 3'b000) begin
                                mem_we    = 1'b1;
                                mem_waddr = {1'b0, ac_q[3:0]};
                                mem_wdata = x_d;
                            end else if (ac_q[6:4] == 3'b100) begin
                                mem_we    = 1'b1;
                                mem_waddr = {1'b1, ac_q[3:0]};
                                mem_wdata = x_d;
                            end
                            ac_d = entry_inc_q ? ac_inc(ac_q) : ac_dec(ac_q);
                        end
                    end
                end
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Character buffer: single write port, registered read port. Contents
    // are not reset; the post-reset sweep initializes them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_50) begin
        if (mem_we)
            buf_mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk_50 or negedge reset) begin
        if (!reset)
            rd_data_q <= 8'h00;
        else
            rd_data_q <= buf_mem[rd_addr];
    end

    assign rd_data    = rd_data_q;
    assign cursor     = ac_q;
    assign disp_on    = disp_on_q;
    assign cursor_on  = cursor_on_q;
    assign blink_on   = blink_on_q;
    assign entry_inc  = entry_inc_q;
    assign two_line   = two_line_q;
    assign bus_8bit   = bus_8bit_q;
    assign busy       = (state_q == ST_SWEEP);
    assign cmd_pulse  = cmd_pulse_q;
    assign data_pulse = data_pulse_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
module tb_lcd_bus_receiver;

    logic       clk_50 = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] lcd_d  = 8'h00;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic       lcd_e  = 1'b0;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_data;
    logic [6:0] cursor;
    logic       disp_on, cursor_on, blink_on, entry_inc, two_line, bus_8bit;
    logic       busy, cmd_pulse, data_pulse, overrun;

    int errors = 0;
    int checks = 0;
    int cmd_cnt = 0;
    int data_cnt = 0;

    lcd_bus_receiver dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .lcd_d      (lcd_d),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor     (cursor),
        .disp_on    (disp_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .entry_inc  (entry_inc),
        .two_line   (two_line),
        .bus_8bit   (bus_8bit),
        .busy       (busy),
        .cmd_pulse  (cmd_pulse),
        .data_pulse (data_pulse),
        .overrun    (overrun)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (cmd_pulse)
            cmd_cnt <= cmd_cnt + 1;
        if (data_pulse)
            data_cnt <= data_cnt + 1;
    end

    // One bus write: E high for two sampled cycles, then gap cycles low.
    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int gap);
        @(posedge clk_50);
        #2;
        lcd_rs = rs;
        lcd_rw = rw;
        lcd_d  = d;
        lcd_e  = 1'b1;
        @(posedge clk_50);
        #2;
        @(posedge clk_50);
        #2;
        lcd_e = 1'b0;
        $display("xfer rs=%0b rw=%0b d=%02h", rs, rw, d);
        repeat (gap) @(posedge clk_50);
    endtask

    task automatic settle();
        repeat (6) @(negedge clk_50);
    endtask

    task automatic read_buf(input logic [4:0] a, output logic [7:0] v);
        @(negedge clk_50);
        rd_addr = a;
        @(negedge clk_50);
        v = rd_data;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy)
                break;
            @(negedge clk_50);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b required 0 within 100 cycles", busy);
        end
    endtask

    task automatic test_reset();
        int cnt;
        logic [7:0] v;
        @(negedge clk_50);
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %02h required 00", rd_data);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %0b required 1", busy);
        end
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy !== 1'b1)
                break;
            cnt++;
            @(negedge clk_50);
        end
        checks++;
        if (cnt !== 32) begin
            errors++;
            $display("FAIL busy_cycles: got %0d required 32", cnt);
        end
        for (int a = 0; a < 32; a++) begin
            read_buf(a[4:0], v);
            checks++;
            if (v !== 8'h20) begin
                errors++;
                $display("FAIL sweep_fill[%0d]: got %02h required 20", a, v);
            end
        end
        checks++;
        if ({cursor, entry_inc, bus_8bit, overrun, disp_on, two_line} !== {7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: cursor=%02h ei=%0b dl=%0b ov=%0b d=%0b n=%0b required 00 1 1 0 0 0",
                     cursor, entry_inc, bus_8bit, overrun, disp_on, two_line);
        end
        $display("test_reset done");
    endtask

    task automatic test_init_sequence();
        int c0, d0;
        logic [7:0] v;
        logic [7:0] exp_b [4];
        exp_b = '{8'h52, 8'h31, 8'h2E, 8'h35};
        c0 = cmd_cnt;
        d0 = data_cnt;
        xfer(1'b0, 1'b0, 8'h38, 6);
        xfer(1'b0, 1'b0, 8'h08, 6);
        xfer(1'b0, 1'b0, 8'h01, 6);
        wait_idle();
        xfer(1'b0, 1'b0, 8'h06, 6);
        xfer(1'b0, 1'b0, 8'h0C, 6);
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 1'b0, exp_b[i], 6);
        settle();
        checks++;
        if ({two_line, bus_8bit, disp_on, cursor_on, blink_on, entry_inc} !== 6'b111001) begin
            errors++;
            $display("FAIL init_ctrl: n=%0b dl=%0b d=%0b c=%0b b=%0b ei=%0b required 1 1 1 0 0 1",
                     two_line, bus_8bit, disp_on, cursor_on, blink_on, entry_inc);
        end
        for (int i = 0; i < 4; i++) begin
            read_buf(i[4:0], v);
            checks++;
            if (v !== exp_b[i]) begin
                errors++;
                $display("FAIL init_buf[%0d]: got %02h required %02h", i, v, exp_b[i]);
            end
        end
        checks++;
        if (cursor !== 7'h04) begin
            errors++;
            $display("FAIL init_cursor: got %02h required 04", cursor);
        end
        checks++;
        if (cmd_cnt - c0 !== 5 || data_cnt - d0 !== 4) begin
            errors++;
            $display("FAIL init_pulses: cmd=%0d data=%0d required 5 4", cmd_cnt - c0, data_cnt - d0);
        end
        $display("test_init_sequence done");
    endtask

    task automatic test_line2();
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'hC0, 6);
        xfer(1'b1, 1'b0, 8'h4D, 6);
        xfer(1'b1, 1'b0, 8'h39, 6);
        settle();
        read_buf(5'd16, v);
        checks++;
        if (v !== 8'h4D) begin
            errors++;
            $display("FAIL line2_buf16: got %02h required 4D", v);
        end
        read_buf(5'd17, v);
        checks++;
        if (v !== 8'h39) begin
            errors++;
            $display("FAIL line2_buf17: got %02h required 39", v);
        end
        checks++;
        if (cursor !== 7'h42) begin
            errors++;
            $display("FAIL line2_cursor: got %02h required 42", cursor);
        end
        $display("test_line2 done");
    endtask

    task automatic test_wrap();
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'hA7, 6);
        xfer(1'b1, 1'b0, 8'h41, 6);
        settle();
        checks++;
        if (cursor !== 7'h40) begin
            errors++;
            $display("FAIL wrap_inc_27: got %02h required 40", cursor);
        end
        read_buf(5'd7, v);
        checks++;
        if (v !== 8'h20) begin
            errors++;
            $display("FAIL wrap_nostore_7: got %02h required 20", v);
        end
        read_buf(5'd23, v);
        checks++;
        if (v !== 8'h20) begin
            errors++;
            $display("FAIL wrap_nostore_23: got %02h required 20", v);
        end
        xfer(1'b0, 1'b0, 8'h04, 6);
        xfer(1'b0, 1'b0, 8'h10, 6);
        settle();
        checks++;
        if (cursor !== 7'h27 || entry_inc !== 1'b0) begin
            errors++;
            $display("FAIL wrap_dec_40: cursor=%02h ei=%0b required 27 0", cursor, entry_inc);
        end
        xfer(1'b0, 1'b0, 8'h80, 6);
        xfer(1'b0, 1'b0, 8'h10, 6);
        settle();
        checks++;
        if (cursor !== 7'h67) begin
            errors++;
            $display("FAIL wrap_dec_00: got %02h required 67", cursor);
        end
        xfer(1'b0, 1'b0, 8'h14, 6);
        settle();
        checks++;
        if (cursor !== 7'h00) begin
            errors++;
            $display("FAIL wrap_inc_67: got %02h required 00", cursor);
        end
        xfer(1'b0, 1'b0, 8'h18, 6);
        xfer(1'b0, 1'b0, 8'h06, 6);
        settle();
        checks++;
        if (cursor !== 7'h00 || entry_inc !== 1'b1) begin
            errors++;
            $display("FAIL wrap_shift_nochange: cursor=%02h ei=%0b required 00 1", cursor, entry_inc);
        end
        $display("test_wrap done");
    endtask

    task automatic test_cgram();
        int d0;
        logic [7:0] v;
        d0 = data_cnt;
        xfer(1'b0, 1'b0, 8'h40, 6);
        xfer(1'b1, 1'b0, 8'h55, 6);
        settle();
        checks++;
        if (data_cnt - d0 !== 1 || cursor !== 7'h00) begin
            errors++;
            $display("FAIL cgram_discard: pulses=%0d cursor=%02h required 1 00", data_cnt - d0, cursor);
        end
        read_buf(5'd0, v);
        checks++;
        if (v !== 8'h52) begin
            errors++;
            $display("FAIL cgram_buf0: got %02h required 52", v);
        end
        xfer(1'b0, 1'b0, 8'h80, 6);
        xfer(1'b1, 1'b0, 8'h55, 6);
        settle();
        read_buf(5'd0, v);
        checks++;
        if (v !== 8'h55 || cursor !== 7'h01) begin
            errors++;
            $display("FAIL ddram_after_cgram: buf0=%02h cursor=%02h required 55 01", v, cursor);
        end
        $display("test_cgram done");
    endtask

    task automatic test_rw_ignored();
        int c0, d0;
        logic [7:0] v;
        c0 = cmd_cnt;
        d0 = data_cnt;
        xfer(1'b1, 1'b1, 8'h77, 6);
        xfer(1'b0, 1'b1, 8'h01, 6);
        settle();
        read_buf(5'd1, v);
        checks++;
        if (cmd_cnt - c0 !== 0 || data_cnt - d0 !== 0 || v !== 8'h31 || cursor !== 7'h01 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rw_ignored: cmd=%0d data=%0d buf1=%02h cursor=%02h busy=%0b required 0 0 31 01 0",
                     cmd_cnt - c0, data_cnt - d0, v, cursor, busy);
        end
        $display("test_rw_ignored done");
    endtask

    task automatic test_back_to_back();
        int d0;
        logic [7:0] v;
        d0 = data_cnt;
        xfer(1'b1, 1'b0, 8'h41, 1);
        xfer(1'b1, 1'b0, 8'h42, 1);
        xfer(1'b1, 1'b0, 8'h43, 1);
        settle();
        for (int i = 0; i < 3; i++) begin
            read_buf(5'(i + 1), v);
            checks++;
            if (v !== 8'(8'h41 + i)) begin
                errors++;
                $display("FAIL b2b_buf[%0d]: got %02h required %02h", i + 1, v, 8'(8'h41 + i));
            end
        end
        checks++;
        if (cursor !== 7'h04 || data_cnt - d0 !== 3) begin
            errors++;
            $display("FAIL b2b_cursor: cursor=%02h pulses=%0d required 04 3", cursor, data_cnt - d0);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_overrun();
        int c0, d0;
        logic [7:0] v;
        c0 = cmd_cnt;
        d0 = data_cnt;
        xfer(1'b0, 1'b0, 8'h80, 6);
        xfer(1'b0, 1'b0, 8'h01, 1);
        xfer(1'b1, 1'b0, 8'h58, 6);
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: ov=%0b busy=%0b required 1 1", overrun, busy);
        end
        wait_idle();
        read_buf(5'd0, v);
        checks++;
        if (v !== 8'h20) begin
            errors++;
            $display("FAIL overrun_buf0: got %02h required 20", v);
        end
        checks++;
        if (cmd_cnt - c0 !== 2 || data_cnt - d0 !== 0 || cursor !== 7'h00) begin
            errors++;
            $display("FAIL overrun_drop: cmd=%0d data=%0d cursor=%02h required 2 0 00",
                     cmd_cnt - c0, data_cnt - d0, cursor);
        end
        xfer(1'b1, 1'b0, 8'h61, 6);
        settle();
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %0b required 1", overrun);
        end
        @(negedge clk_50);
        reset = 1'b0;
        #1;
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1 || cursor !== 7'h00 || disp_on !== 1'b0 || two_line !== 1'b0) begin
            errors++;
            $display("FAIL overrun_reset: ov=%0b busy=%0b cursor=%02h d=%0b n=%0b required 0 1 00 0 0",
                     overrun, busy, cursor, disp_on, two_line);
        end
        @(negedge clk_50);
        reset = 1'b1;
        wait_idle();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_after_reset: got %0b required 0", overrun);
        end
        $display("test_overrun done");
    endtask

    initial begin
        repeat (3) @(negedge clk_50);
        test_reset();
        test_init_sequence();
        test_line2();
        test_wrap();
        test_cgram();
        test_rw_ignored();
        test_back_to_back();
        test_overrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
